// File: rtl/pdu_debug_unit.sv
// Board-side debug unit for the pipelined CPU: button debounce, run/step clock
// and reset generation, memory-mapped LEDs/switches/display, and a PC/debug-word viewer.
//
// state    | meaning
// MODE_IO  | display shows seg_data written by the CPU
// MODE_PC  | display shows current_pc
// MODE_CHK | display shows chk_data at chk_addr
module pdu_debug_unit #(
    parameter int DEBOUNCE = 16,
    parameter int SCAN     = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        butu,
    input  logic        butd,
    input  logic        butr,
    input  logic        butc,
    input  logic        butl,
    input  logic [15:0] sw,
    output logic        cpu_stop,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic [2:0]  seg_sel,
    output logic        clk_cpu,
    output logic        rstn_cpu,
    input  logic [15:0] io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_rd,
    output logic [31:0] io_din,
    input  logic [31:0] current_pc,
    output logic [15:0] chk_addr,
    input  logic [31:0] chk_data
);

    localparam int DBW = $clog2(DEBOUNCE) + 1;
    localparam int SCW = (SCAN > 1) ? $clog2(SCAN) : 1;

    typedef enum logic [1:0] {MODE_IO, MODE_PC, MODE_CHK} mode_t;

    // button vector order: {l, c, r, d, u}
    logic [4:0]     but_s1, but_s2, but_lvl, but_lvl_d, but_evt;
    logic [DBW-1:0] db_cnt [5];
    logic [15:0]    sw_s1, sw_s2;
    logic           run;
    logic [31:0]    seg_data;
    mode_t          mode_q, mode_n;
    logic [SCW-1:0] scan_cnt;
    logic [2:0]     digit;
    logic [31:0]    disp_word;
    logic [3:0]     nibble;
    logic [6:0]     hex_seg;
    logic           unused_bits;

    assign unused_bits = ^{io_rd, io_addr[15:8]};
    assign but_evt     = but_lvl & ~but_lvl_d;

    always_ff @(posedge clk) begin
        if (rstn) begin
            but_s1    <= '0;
            but_s2    <= '0;
            but_lvl   <= '0;
            but_lvl_d <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
            sw_s1     <= '0;
            sw_s2     <= '0;
        end else begin
            but_s1    <= {butl, butc, butr, butd, butu};
            but_s2    <= but_s1;
            but_lvl_d <= but_lvl;
            sw_s1     <= sw;
            sw_s2     <= sw_s1;
            // level only follows the synchronized input after a full stable run
            for (int i = 0; i < 5; i++) begin
                if (but_s2[i] != but_lvl[i]) begin
                    if (db_cnt[i] == DBW'(DEBOUNCE - 1)) begin
                        but_lvl[i] <= but_s2[i];
                        db_cnt[i]  <= '0;
                    end else begin
                        db_cnt[i]  <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        rstn_cpu <= ~rstn;
        if (rstn) begin
            run      <= 1'b0;
            clk_cpu  <= 1'b0;
            chk_addr <= '0;
            led      <= '0;
            seg_data <= '0;
        end else begin
            if (but_evt[3]) run <= ~run;
            if (run)             clk_cpu <= ~clk_cpu;
            else if (but_evt[2]) clk_cpu <= 1'b1;
            else                 clk_cpu <= 1'b0;
            if (!run) begin
                if (but_evt[0] && !but_evt[1])      chk_addr <= chk_addr + 16'd1;
                else if (but_evt[1] && !but_evt[0]) chk_addr <= chk_addr - 16'd1;
            end
            if (io_we) begin
                case (io_addr[7:0])
                    8'h00:   led      <= io_dout[15:0];
                    8'h08:   seg_data <= io_dout;
                    default: ;
                endcase
            end
        end
    end

    assign cpu_stop = ~run;

    always_comb begin
        io_din = '0;
        case (io_addr[7:0])
            8'h0C:   io_din = {16'b0, sw_s2};
            8'h10:   io_din = {27'b0, but_lvl};
            8'h14:   io_din = {31'b0, run};
            default: io_din = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) mode_q <= MODE_IO;
        else      mode_q <= mode_n;
    end

    always_comb begin
        mode_n    = mode_q;
        seg_sel   = 3'b001;
        disp_word = seg_data;
        if (but_evt[4]) begin
            case (mode_q)
                MODE_IO:  mode_n = MODE_PC;
                MODE_PC:  mode_n = MODE_CHK;
                default:  mode_n = MODE_IO;
            endcase
        end
        case (mode_q)
            MODE_PC:  begin seg_sel = 3'b010; disp_word = current_pc; end
            MODE_CHK: begin seg_sel = 3'b100; disp_word = chk_data;   end
            default:  begin seg_sel = 3'b001; disp_word = seg_data;   end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            scan_cnt <= SCW'(SCAN - 1);
            digit    <= '0;
        end else if (scan_cnt == '0) begin
            scan_cnt <= SCW'(SCAN - 1);
            digit    <= digit + 3'd1;
        end else begin
            scan_cnt <= scan_cnt - 1'b1;
        end
    end

    assign nibble = disp_word[{digit, 2'b00} +: 4];
    assign an     = ~(8'b1 << digit);
    assign seg    = ~hex_seg;

    always_comb begin
        hex_seg = 7'h00;
        case (nibble)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    end

endmodule

// File: tb/tb_pdu_debug_unit.sv
// Directed bench for pdu_debug_unit: reset, I/O map, step/run clocking,
// check-address buttons, display modes and scan decode.
module tb_pdu_debug_unit;

    localparam int SCAN_TB = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        butu = 0, butd = 0, butr = 0, butc = 0, butl = 0;
    logic [15:0] sw = '0;
    logic        cpu_stop;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [2:0]  seg_sel;
    logic        clk_cpu;
    logic        rstn_cpu;
    logic [15:0] io_addr = '0;
    logic [31:0] io_dout = '0;
    logic        io_we = 1'b0;
    logic        io_rd = 1'b0;
    logic [31:0] io_din;
    logic [31:0] current_pc = '0;
    logic [15:0] chk_addr;
    logic [31:0] chk_data = '0;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    pdu_debug_unit #(.DEBOUNCE(16), .SCAN(SCAN_TB)) dut (
        .clk(clk), .rstn(rstn),
        .butu(butu), .butd(butd), .butr(butr), .butc(butc), .butl(butl),
        .sw(sw), .cpu_stop(cpu_stop), .led(led), .an(an), .seg(seg),
        .seg_sel(seg_sel), .clk_cpu(clk_cpu), .rstn_cpu(rstn_cpu),
        .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd),
        .io_din(io_din), .current_pc(current_pc), .chk_addr(chk_addr),
        .chk_data(chk_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: butu = v;
            1: butd = v;
            2: butr = v;
            3: butc = v;
            default: butl = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        cyc(25);
        set_btn(b, 1'b0);
        cyc(25);
    endtask

    task automatic io_write(input logic [7:0] a, input logic [31:0] d);
        io_addr = {8'h00, a};
        io_dout = d;
        io_we   = 1'b1;
        cyc(1);
        io_we   = 1'b0;
    endtask

    // waits (bounded) for digit i to be lit, then checks its segments
    task automatic check_digit(input string tag, input int i, input logic [3:0] nib);
        logic [7:0] tgt;
        bit ok;
        tgt = ~(8'(1) << i);
        ok  = 1'b0;
        for (int k = 0; k < 10 * SCAN_TB; k++) begin
            if (an === tgt) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        chk({tag, "_an"}, {31'b0, ok}, 32'd1);
        chk(tag, {25'b0, seg}, {25'b0, ~hex7[nib]});
    endtask

    initial begin
        int highs;
        logic a0, a1, a2;
        logic [31:0] disp;

        // reset
        rstn = 1'b1;
        cyc(3);
        chk("rst_cpu_stop", {31'b0, cpu_stop}, 32'd1);
        chk("rst_clk_cpu", {31'b0, clk_cpu}, 32'd0);
        chk("rst_led", {16'b0, led}, 32'd0);
        chk("rst_an", {24'b0, an}, 32'hFE);
        chk("rst_seg_sel", {29'b0, seg_sel}, 32'd1);
        chk("rst_chk_addr", {16'b0, chk_addr}, 32'd0);
        chk("rst_rstn_cpu", {31'b0, rstn_cpu}, 32'd0);
        rstn = 1'b0;
        cyc(2);
        chk("rstn_cpu_release", {31'b0, rstn_cpu}, 32'd1);

        // LED and display write
        io_write(8'h00, 32'h0000_A5A5);
        chk("led_write", {16'b0, led}, 32'h0000_A5A5);
        io_write(8'h20, 32'hFFFF_FFFF);
        chk("led_other_addr", {16'b0, led}, 32'h0000_A5A5);
        io_write(8'h08, 32'h1234_5678);
        disp = 32'h1234_5678;
        for (int i = 0; i < 8; i++) check_digit($sformatf("io_digit%0d", i), i, disp[i*4 +: 4]);

        // reads
        sw = 16'hBEEF;
        cyc(3);
        io_addr = 16'h000C;
        #1 chk("rd_sw", io_din, 32'h0000_BEEF);
        io_addr = 16'h0020;
        #1 chk("rd_unmapped", io_din, 32'h0);
        io_addr = 16'h0014;
        #1 chk("rd_run_stopped", io_din, 32'h0);
        io_addr = 16'h0010;
        #1 chk("rd_buttons_idle", io_din, 32'h0);
        butc = 1'b1;
        cyc(22);
        chk("rd_buttons_c", io_din, 32'h0000_0008);
        butc = 1'b0;
        cyc(25);
        chk("run_after_level_read", {31'b0, cpu_stop}, 32'd0);
        press(3);
        chk("stopped_again", {31'b0, cpu_stop}, 32'd1);

        // single step
        highs = 0;
        butr = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (clk_cpu === 1'b1) highs++;
            if (i == 24) butr = 1'b0;
        end
        chk("step_one_pulse", highs, 32'd1);
        highs = 0;
        butr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (clk_cpu === 1'b1) highs++;
            if (i == 4) butr = 1'b0;
        end
        chk("bounce_no_pulse", highs, 32'd0);

        // check address while stopped
        press(1);
        chk("chk_dec_wrap", {16'b0, chk_addr}, 32'h0000_FFFF);
        press(0);
        press(0);
        chk("chk_inc_twice", {16'b0, chk_addr}, 32'h0000_0001);
        butu = 1'b1; butd = 1'b1;
        cyc(25);
        butu = 1'b0; butd = 1'b0;
        cyc(25);
        chk("chk_simul", {16'b0, chk_addr}, 32'h0000_0001);

        // run / stop
        press(3);
        chk("run_cpu_stop", {31'b0, cpu_stop}, 32'd0);
        a0 = clk_cpu; cyc(1); a1 = clk_cpu; cyc(1); a2 = clk_cpu;
        chk("run_toggle1", {31'b0, a1}, {31'b0, ~a0});
        chk("run_toggle2", {31'b0, a2}, {31'b0, ~a1});
        io_addr = 16'h0014;
        #1 chk("rd_run_running", io_din, 32'h1);
        press(0);
        chk("chk_run_ignored", {16'b0, chk_addr}, 32'h0000_0001);
        press(3);
        chk("stop_cpu_stop", {31'b0, cpu_stop}, 32'd1);
        chk("stop_clk_low", {31'b0, clk_cpu}, 32'd0);

        // mode cycling
        current_pc = 32'h0000_3000;
        chk_data   = 32'h0000_00AD;
        press(4);
        chk("mode_pc", {29'b0, seg_sel}, 32'b010);
        check_digit("pc_digit3", 3, 4'h3);
        check_digit("pc_digit0", 0, 4'h0);
        press(4);
        chk("mode_chk", {29'b0, seg_sel}, 32'b100);
        check_digit("chk_digit0", 0, 4'hD);
        check_digit("chk_digit1", 1, 4'hA);
        // long hold still counts as one press
        butl = 1'b1;
        cyc(150);
        butl = 1'b0;
        cyc(25);
        chk("mode_io_held", {29'b0, seg_sel}, 32'b001);

        // reset while running
        press(3);
        io_write(8'h00, 32'h0000_0055);
        chk("pre_rst_run", {31'b0, cpu_stop}, 32'd0);
        rstn = 1'b1;
        cyc(1);
        chk("mid_rst_cpu_stop", {31'b0, cpu_stop}, 32'd1);
        chk("mid_rst_clk_cpu", {31'b0, clk_cpu}, 32'd0);
        chk("mid_rst_led", {16'b0, led}, 32'd0);
        chk("mid_rst_chk_addr", {16'b0, chk_addr}, 32'd0);
        chk("mid_rst_rstn_cpu", {31'b0, rstn_cpu}, 32'd0);
        rstn = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdu_debug_unit.md
# pdu_debug_unit

Processor debug unit between the board I/O (buttons, switches, LEDs, 8-digit seven-segment display) and the pipelined CPU. It generates the CPU clock (free-run or single-step) and CPU reset, and exposes a memory-mapped I/O bus for LEDs, switches and display data. It also provides a debug path that shows the current PC or a memory/register word selected by a check address.

## Interface
- `DEBOUNCE`, 16: consecutive stable cycles required before a button level is accepted.
- `SCAN`, 1024: clk cycles each display digit is lit.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rstn` input 1: synchronous, active-high reset (1 = reset). The name is kept from the board pin.
- `butu`, `butd`, `butr`, `butc`, `butl` input 1 each: raw push buttons, asynchronous.
- `sw` input 16: raw switches.
- `cpu_stop` output 1: 1 = CPU halted.
- `led` output 16: LED register.
- `an` output 8: digit enables, active-low, one-hot.
- `seg` output 7: segments a–g (bit0 = a), active-low.
- `seg_sel` output 3: display-source indicator, one-hot.
- `clk_cpu` output 1: CPU clock.
- `rstn_cpu` output 1: CPU reset, active-low.
- `io_addr` input 16, `io_dout` input 32, `io_we` input 1, `io_rd` input 1: CPU I/O request.
- `io_din` output 32: I/O read data.
- `current_pc` input 32: CPU PC.
- `chk_addr` output 16: debug address.
- `chk_data` input 32: debug data.

## Operation
- **Buttons.** Each button passes through a 2-flop synchronizer. A stable level register updates when the synchronized value has differed from it for `DEBOUNCE` consecutive cycles. A one-cycle press event fires in the cycle after the stable level goes 0→1.
- **Run control.** `run` register.
  - butc event toggles `run`.
  - `cpu_stop` = ~run.
- **CPU clock.**
  - While `run` is set, `clk_cpu` toggles every clk cycle (clk/2).
  - While stopped, a butr event produces exactly one `clk_cpu` high pulse of one clk cycle, then `clk_cpu` returns low.
  - Entering stop forces `clk_cpu` low on the next cycle.
  - butr is ignored while running.
- **CPU reset.** `rstn_cpu` is a register equal to ~rstn delayed one cycle.
- **Check address.**
  - butu event increments `chk_addr`; butd event decrements it. Both wrap modulo 2^16.
  - Only effective while stopped.
  - A simultaneous butu and butd event leaves `chk_addr` unchanged.
- **Display mode.** butl event cycles the mode IO → PC → CHK → IO.
  - `seg_sel` is 3'b001 in IO mode, 3'b010 in PC mode, 3'b100 in CHK mode.
  - The displayed word is `seg_data` (IO), `current_pc` (PC) or `chk_data` (CHK).
- **I/O map.** Decode uses `io_addr[7:0]`.
  - 0x00: write sets `led` = io_dout[15:0].
  - 0x08: write sets `seg_data` = io_dout.
  - 0x0C: read returns {16'b0, sw}, with `sw` synchronized by 2 flops.
  - 0x10: read returns {27'b0, butl, butc, butr, butd, butu}, using the debounced levels.
  - 0x14: read returns {31'b0, run}.
  - Writes to other addresses are ignored; reads of other addresses return 0.
  - `io_din` is combinational from `io_addr` and is independent of `io_rd`. `io_rd` has no side effects.
- **Display scan.** A digit counter d (0..7) advances every `SCAN` cycles and wraps from 7 to 0.
  - `an` = ~(1<<d).
  - `seg` is the active-low hex decode of nibble d of the displayed word. Digit 0 is the rightmost digit.
  - Decode, hex digit → gfedcba active-high before inversion: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.

## Timing
- **Reset values (applied while rstn=1):**
  - run=0, `cpu_stop`=1, `clk_cpu`=0, `led`=0, `seg_data`=0, `chk_addr`=0.
  - Mode IO, `seg_sel`=3'b001.
  - d=0, `an`=8'hFE.
  - Debounce levels and counters 0, no events.
  - `rstn_cpu`=0 one cycle after rstn asserts.
- **I/O timing.**
  - I/O writes take effect at the clk edge where `io_we`=1.
  - The new value is visible on `led` and in readback in the next cycle.
- **Event to effect.** A press event changes run, mode, chk_addr or the step pulse at the following edge.
- **Reset mid-operation.** A reset during a step pulse or while running returns to the reset state at the next edge.
- **Held buttons.** A held button produces exactly one event per press. Bounces shorter than `DEBOUNCE` cycles produce no event.

## Test plan
- **Reset.** Assert rstn for 3 cycles. Expect `cpu_stop`=1, `clk_cpu`=0, `led`=0, `an`=FE, `seg_sel`=001, `chk_addr`=0, `rstn_cpu`=0.
- **LED and display write.**
  - Write 0x00 with 0x0000_A5A5; expect `led`=A5A5.
  - Write 0x08 with 0x1234_5678; over 8 scan slots expect digit 0 `seg`=~7F (8), digit 7 `seg`=~06 (1).
  - Read 0x0C with sw=0xBEEF; expect `io_din`=0x0000_BEEF. Read 0x20; expect 0.
- **Single step.** While stopped, press butr once. Expect exactly one `clk_cpu` high cycle. A 5-cycle bounce (< DEBOUNCE) produces no pulse.
- **Run/stop.** Press butc. Expect `cpu_stop`=0 and `clk_cpu` alternating every cycle. Press butc again. Expect `cpu_stop`=1 and `clk_cpu`=0.
- **Check address.**
  - While stopped, press butd at 0. Expect `chk_addr`=FFFF; press butu twice; expect 0001.
  - While running, butu leaves `chk_addr` unchanged.
- **Mode cycling.** Three butl presses step `seg_sel` 010, 100, 001. In PC mode with `current_pc`=0x0000_3000, digit 3 shows 3.
